// File: rtl/reset_vector_sequencer.sv
// Purpose: after the timing reset releases, run the 6502 reset microsequence and hand PC to the core.
// Latency: PC_LOAD/SYNC arrive 2+NUM_PUSH+2+1 cycles after leaving HOLD, plus one cycle per RDY-low cycle.
// Backpressure: RDY low freezes DUM/PUSH/VLO/VHI (state, count, S, lo, hi, ADDR); HOLD and FETCH ignore RDY.
module reset_vector_sequencer #(
    parameter logic [15:0] VEC_ADDR   = 16'hFFFC,
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter int          NUM_PUSH   = 3
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        TRESET,
    input  logic        RDY,
    input  logic [7:0]  DIN,
    input  logic [15:0] PC_IN,
    input  logic [7:0]  S_IN,
    output logic [15:0] ADDR,
    output logic        RW,
    output logic        ACTIVE,
    output logic [7:0]  S_OUT,
    output logic        S_WE,
    output logic [15:0] PC_OUT,
    output logic        PC_LOAD,
    output logic        SYNC,
    output logic [2:0]  STATE
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_DUM   = 3'd2;
    localparam logic [2:0] ST_PUSH  = 3'd3;
    localparam logic [2:0] ST_VLO   = 3'd4;
    localparam logic [2:0] ST_VHI   = 3'd5;
    localparam logic [2:0] ST_FETCH = 3'd6;

    localparam logic [2:0] LAST_DUM  = 3'd1;
    localparam logic [2:0] LAST_PUSH = 3'(NUM_PUSH - 1);

    logic [2:0] state;
    logic [2:0] cnt;
    logic [7:0] s_reg;
    logic [7:0] lo;
    logic [7:0] hi;

    // Sequencer state: RESET beats TRESET, TRESET beats everything else, RDY gates the read cycles.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            s_reg <= 8'd0;
            lo    <= 8'd0;
            hi    <= 8'd0;
        end else if (TRESET) begin
            state <= ST_HOLD;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_HOLD: begin
                    s_reg <= S_IN;
                    cnt   <= 3'd0;
                    state <= ST_DUM;
                end
                ST_DUM: begin
                    if (RDY) begin
                        if (cnt == LAST_DUM) begin
                            cnt   <= 3'd0;
                            state <= ST_PUSH;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                ST_PUSH: begin
                    if (RDY) begin
                        s_reg <= s_reg - 8'd1;
                        if (cnt == LAST_PUSH) begin
                            cnt   <= 3'd0;
                            state <= ST_VLO;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                ST_VLO: begin
                    if (RDY) begin
                        lo    <= DIN;
                        state <= ST_VHI;
                    end
                end
                ST_VHI: begin
                    if (RDY) begin
                        hi    <= DIN;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus and register-file strobes decoded from the registered state; the stack write is
    // suppressed whenever the push cannot complete this cycle (stall or abort).
    always_comb begin
        ADDR    = 16'h0000;
        ACTIVE  = 1'b0;
        S_OUT   = 8'h00;
        S_WE    = 1'b0;
        PC_OUT  = 16'h0000;
        PC_LOAD = 1'b0;
        SYNC    = 1'b0;
        case (state)
            ST_HOLD, ST_DUM: begin
                ADDR   = PC_IN;
                ACTIVE = 1'b1;
            end
            ST_PUSH: begin
                ADDR   = {STACK_PAGE, s_reg};
                ACTIVE = 1'b1;
                S_OUT  = s_reg - 8'd1;
                S_WE   = RDY & ~TRESET & ~RESET;
            end
            ST_VLO: begin
                ADDR   = VEC_ADDR;
                ACTIVE = 1'b1;
            end
            ST_VHI: begin
                ADDR   = VEC_ADDR + 16'd1;
                ACTIVE = 1'b1;
            end
            ST_FETCH: begin
                ADDR    = {hi, lo};
                ACTIVE  = 1'b1;
                PC_OUT  = {hi, lo};
                PC_LOAD = 1'b1;
                SYNC    = 1'b1;
            end
            default: begin
                ADDR = 16'h0000;
            end
        endcase
    end

    assign RW    = 1'b1;
    assign STATE = state;

endmodule

// File: tb/tb_reset_vector_sequencer.sv
// Purpose: checks two sequencer instances (default and NUM_PUSH=1/VEC_ADDR=FFFA) against a bus-cycle list model.
// Latency: model is per-cycle; directed runs also pin the PC_LOAD cycle index by hand.
// Backpressure: RDY stalls and TRESET/RESET aborts are driven directly by the stimulus.
module tb_reset_vector_sequencer;

    logic        Clk = 1'b0;
    logic        RESET, TRESET, RDY;
    logic [7:0]  DIN, S_IN;
    logic [15:0] PC_IN;

    logic [15:0] addr_o [2];
    logic        rw_o   [2];
    logic        act_o  [2];
    logic [7:0]  so_o   [2];
    logic        we_o   [2];
    logic [15:0] pco_o  [2];
    logic        ld_o   [2];
    logic        sy_o   [2];
    logic [2:0]  st_o   [2];

    always #5 Clk = ~Clk;

    reset_vector_sequencer u0 (
        .Clk(Clk), .RESET(RESET), .TRESET(TRESET), .RDY(RDY), .DIN(DIN), .PC_IN(PC_IN), .S_IN(S_IN),
        .ADDR(addr_o[0]), .RW(rw_o[0]), .ACTIVE(act_o[0]), .S_OUT(so_o[0]), .S_WE(we_o[0]),
        .PC_OUT(pco_o[0]), .PC_LOAD(ld_o[0]), .SYNC(sy_o[0]), .STATE(st_o[0])
    );

    reset_vector_sequencer #(.VEC_ADDR(16'hFFFA), .STACK_PAGE(8'h01), .NUM_PUSH(1)) u1 (
        .Clk(Clk), .RESET(RESET), .TRESET(TRESET), .RDY(RDY), .DIN(DIN), .PC_IN(PC_IN), .S_IN(S_IN),
        .ADDR(addr_o[1]), .RW(rw_o[1]), .ACTIVE(act_o[1]), .S_OUT(so_o[1]), .S_WE(we_o[1]),
        .PC_OUT(pco_o[1]), .PC_LOAD(ld_o[1]), .SYNC(sy_o[1]), .STATE(st_o[1])
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // ---------------- model: list of bus cycles still to be issued ----------------
    localparam logic [2:0] K_PC    = 3'd2;
    localparam logic [2:0] K_PUSH  = 3'd3;
    localparam logic [2:0] K_VLO   = 3'd4;
    localparam logic [2:0] K_VHI   = 3'd5;
    localparam logic [2:0] K_FETCH = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [7:0]  sout;
    } ent_t;

    ent_t       sq [2][16];
    int         hd [2];
    int         ln [2];
    int         md [2];   // 0 = idle, 1 = held by TRESET, 2 = running the cycle list
    logic [7:0] mlo [2];
    logic [7:0] mhi [2];

    function automatic int np_of(input int p);
        return (p == 0) ? 3 : 1;
    endfunction

    function automatic logic [15:0] vec_of(input int p);
        return (p == 0) ? 16'hFFFC : 16'hFFFA;
    endfunction

    task automatic add_ent(input int p, input logic [2:0] k, input logic [15:0] a, input logic [7:0] so);
        sq[p][ln[p]] = {k, a, so};
        ln[p] = ln[p] + 1;
    endtask

    always @(posedge Clk) begin
        for (int p = 0; p < 2; p++) begin
            if (RESET) begin
                md[p] = 0; ln[p] = 0; hd[p] = 0;
            end else if (TRESET) begin
                md[p] = 1; ln[p] = 0; hd[p] = 0;
            end else if (md[p] == 1) begin
                hd[p] = 0; ln[p] = 0;
                add_ent(p, K_PC, 16'h0, 8'h0);
                add_ent(p, K_PC, 16'h0, 8'h0);
                for (int k = 0; k < np_of(p); k++) begin
                    logic [7:0] s;
                    s = S_IN - 8'(k);
                    add_ent(p, K_PUSH, {8'h01, s}, s - 8'd1);
                end
                add_ent(p, K_VLO, 16'h0, 8'h0);
                add_ent(p, K_VHI, 16'h0, 8'h0);
                add_ent(p, K_FETCH, 16'h0, 8'h0);
                md[p] = 2;
            end else if (md[p] == 2) begin
                if (sq[p][hd[p]].kind == K_FETCH) begin
                    md[p] = 0;
                end else if (RDY) begin
                    if (sq[p][hd[p]].kind == K_VLO) mlo[p] = DIN;
                    if (sq[p][hd[p]].kind == K_VHI) mhi[p] = DIN;
                    hd[p] = hd[p] + 1;
                end
            end
        end
    end

    function automatic logic [47:0] model_out(input int p);
        logic [15:0] a   = 16'h0;
        logic        act = 1'b0;
        logic [7:0]  so  = 8'h0;
        logic        we  = 1'b0;
        logic [15:0] pco = 16'h0;
        logic        ld  = 1'b0;
        logic        sy  = 1'b0;
        logic [2:0]  st  = 3'd0;
        ent_t        e;
        if (md[p] == 1) begin
            a = PC_IN; act = 1'b1; st = 3'd1;
        end else if (md[p] == 2) begin
            e   = sq[p][hd[p]];
            st  = e.kind;
            act = 1'b1;
            case (e.kind)
                K_PC:    a = PC_IN;
                K_PUSH:  begin a = e.addr; so = e.sout; we = RDY & ~TRESET & ~RESET; end
                K_VLO:   a = vec_of(p);
                K_VHI:   a = vec_of(p) + 16'd1;
                K_FETCH: begin a = {mhi[p], mlo[p]}; pco = a; ld = 1'b1; sy = 1'b1; end
                default: a = 16'h0;
            endcase
        end
        return {a, 1'b1, act, so, we, pco, ld, sy, st};
    endfunction

    function automatic logic [47:0] dut_out(input int p);
        return {addr_o[p], rw_o[p], act_o[p], so_o[p], we_o[p], pco_o[p], ld_o[p], sy_o[p], st_o[p]};
    endfunction

    // per-cycle comparison of both instances against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("cycle_u%0d", p), dut_out(p), model_out(p));
            end
        end
    end

    // ---------------- directed stimulus and hand-computed expectations ----------------
    logic [15:0] alog   [2][24];
    logic [2:0]  stlog  [2][24];
    logic [2:0]  strb   [2][24];
    logic        actlog [2][24];
    logic [7:0]  solog  [24];
    int          load_idx [2];
    logic [15:0] pcv    [2];
    int          we_cnt [2];

    logic [15:0] exp_basic [8] = '{16'h1234, 16'h1234, 16'h01FD, 16'h01FC, 16'h01FB, 16'hFFFC, 16'hFFFD, 16'hC000};
    logic [15:0] exp_p1    [6] = '{16'h1234, 16'h1234, 16'h01FD, 16'hFFFA, 16'hFFFB, 16'hEAEA};
    logic [7:0]  exp_so    [3] = '{8'hFC, 8'hFB, 8'hFA};
    logic [15:0] exp_wrap  [3] = '{16'h0101, 16'h0100, 16'h01FF};
    logic [7:0]  exp_wso   [3] = '{8'h00, 8'hFF, 8'hFE};
    logic [15:0] exp_fresh [3] = '{16'h0180, 16'h017F, 16'h017E};

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Starts from HOLD with TRESET high; cycle index 0 is the first cycle after leaving HOLD.
    task automatic run_seq(input logic [7:0] s, input logic [7:0] lo, input logic [7:0] hi,
                           input int stall_at, input int stall_len, input int abort_at,
                           input int prio_at, input int ncyc);
        int vlo;
        vlo    = 2 + 3 + stall_len;
        S_IN   = s;
        TRESET = 1'b0;
        DIN    = 8'hEA;
        for (int p = 0; p < 2; p++) begin
            load_idx[p] = -1; pcv[p] = 16'h0; we_cnt[p] = 0;
        end
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            RDY = (i >= stall_at && i < stall_at + stall_len) ? 1'b0 : 1'b1;
            DIN = (i == vlo) ? lo : (i == vlo + 1) ? hi : 8'hEA;
            if (i == abort_at) TRESET = 1'b1;
            if (i == prio_at) begin RESET = 1'b1; TRESET = 1'b1; end
            @(negedge Clk);
            solog[i] = so_o[0];
            for (int p = 0; p < 2; p++) begin
                alog[p][i]   = addr_o[p];
                stlog[p][i]  = st_o[p];
                actlog[p][i] = act_o[p];
                strb[p][i]   = {we_o[p], ld_o[p], sy_o[p]};
                if (we_o[p]) we_cnt[p]++;
                if (ld_o[p] && load_idx[p] < 0) begin
                    load_idx[p] = i;
                    pcv[p] = pco_o[p];
                end
            end
        end
        RDY = 1'b1;
    endtask

    initial begin
        RESET = 1'b1; TRESET = 1'b0; RDY = 1'b1; DIN = 8'hEA; PC_IN = 16'h1234; S_IN = 8'hFD;
        cyc();
        chk_en = 1'b1;
        cyc();
        @(negedge Clk);
        check("reset_state", 48'(st_o[0]), 48'd0);
        check("reset_addr_active", 48'({addr_o[0], act_o[0], rw_o[0]}), 48'({16'h0, 1'b0, 1'b1}));

        RESET = 1'b0; TRESET = 1'b1;
        repeat (5) cyc();
        @(negedge Clk);
        check("hold_outputs", 48'({addr_o[0], act_o[0], st_o[0]}), 48'({16'h1234, 1'b1, 3'd1}));

        // basic sequence
        run_seq(8'hFD, 8'h00, 8'hC0, 99, 0, 99, 99, 10);
        for (int i = 0; i < 8; i++) check($sformatf("basic_addr%0d", i), 48'(alog[0][i]), 48'(exp_basic[i]));
        for (int i = 0; i < 3; i++) check($sformatf("basic_sout%0d", i), 48'(solog[i+2]), 48'(exp_so[i]));
        check("basic_we_cnt", 48'(we_cnt[0]), 48'd3);
        check("basic_load_idx", 48'(load_idx[0]), 48'd7);
        check("basic_pc_out", 48'(pcv[0]), 48'h00C000);
        check("basic_strobes_fetch", 48'(strb[0][7]), 48'b011);
        check("basic_idle_after", 48'({actlog[0][8], strb[0][8]}), 48'd0);
        for (int i = 0; i < 6; i++) check($sformatf("p1_addr%0d", i), 48'(alog[1][i]), 48'(exp_p1[i]));
        check("p1_load_idx", 48'(load_idx[1]), 48'd5);

        // stack pointer wrap
        TRESET = 1'b1; cyc();
        run_seq(8'h01, 8'h12, 8'h34, 99, 0, 99, 99, 10);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap_addr%0d", i), 48'(alog[0][i+2]), 48'(exp_wrap[i]));
            check($sformatf("wrap_sout%0d", i), 48'(solog[i+2]), 48'(exp_wso[i]));
        end
        check("wrap_pc_out", 48'(pcv[0]), 48'h003412);

        // RDY stall across the second push
        TRESET = 1'b1; cyc();
        run_seq(8'hFD, 8'h00, 8'hC0, 3, 3, 99, 99, 13);
        for (int i = 3; i < 7; i++) check($sformatf("stall_addr%0d", i), 48'(alog[0][i]), 48'h0001FC);
        check("stall_we_during", 48'({strb[0][3], strb[0][4], strb[0][5]}), 48'd0);
        check("stall_we_cnt", 48'(we_cnt[0]), 48'd3);
        check("stall_load_idx", 48'(load_idx[0]), 48'd10);
        check("stall_pc_out", 48'(pcv[0]), 48'h00C000);

        // abort during VLO, then a fresh sequence
        TRESET = 1'b1; cyc();
        run_seq(8'hFD, 8'h55, 8'h66, 99, 0, 5, 99, 10);
        check("abort_state", 48'(stlog[0][6]), 48'd1);
        check("abort_no_load", 48'(load_idx[0]), 48'hFFFFFFFFFFFF);
        run_seq(8'h80, 8'h00, 8'h90, 99, 0, 99, 99, 10);
        for (int i = 0; i < 3; i++) check($sformatf("fresh_addr%0d", i), 48'(alog[0][i+2]), 48'(exp_fresh[i]));
        check("fresh_load_idx", 48'(load_idx[0]), 48'd7);
        check("fresh_pc_out", 48'(pcv[0]), 48'h009000);

        // RESET and TRESET together mid-push
        TRESET = 1'b1; cyc();
        run_seq(8'hFD, 8'h00, 8'hC0, 99, 0, 99, 3, 6);
        check("prio_idle", 48'({stlog[0][4], actlog[0][4], strb[0][4]}), 48'd0);
        RESET = 1'b0;
        cyc();
        @(negedge Clk);
        check("prio_hold_u0", 48'(st_o[0]), 48'd1);
        check("prio_hold_u1", 48'(st_o[1]), 48'd1);

        TRESET = 1'b0;
        repeat (3) cyc();
        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reset_vector_sequencer.md
Name: reset_vector_sequencer

Overview:
- Downstream consumer of the TRESET timing-reset stage.
- While TRESET is high it holds the CPU core idle. After TRESET falls it runs the 7-cycle 6502 reset microsequence: two dummy PC reads, three suppressed stack "pushes" (reads with S decrement), then the vector low/high fetch.
- It then loads PC and pulses SYNC for the first opcode fetch.
- It drives the address bus and the PC/S load strobes of the register file during the sequence.

Parameters:
VEC_ADDR, 16'hFFFC, address of reset vector low byte; high byte at VEC_ADDR+1
STACK_PAGE, 8'h01, high byte of stack addresses
NUM_PUSH, 3, number of suppressed push cycles (1..7)

Ports:
Clk  in  1  system clock; all state updates on rising edge
RESET  in  1  synchronous, active-high block reset
TRESET  in  1  timing reset from upstream stage; high = hold
RDY  in  1  6502 RDY; low stalls the sequence (read cycles)
DIN  in  8  data bus read value
PC_IN  in  16  current program counter
S_IN  in  8  current stack pointer
ADDR  out  16  address bus
RW  out  1  1 = read; constant 1 from this block
ACTIVE  out  1  high while the block owns the bus (HOLD through FETCH)
S_OUT  out  8  decremented stack pointer
S_WE  out  1  S_OUT valid, write to S this cycle
PC_OUT  out  16  assembled vector
PC_LOAD  out  1  one-cycle strobe to load PC_OUT
SYNC  out  1  opcode fetch cycle marker
STATE  out  3  encoded state, for debug

Behaviour:
- States: IDLE=0, HOLD=1, DUM=2, PUSH=3, VLO=4, VHI=5, FETCH=6. DUM and PUSH each have an internal cycle count.
- RESET=1: next state IDLE; clear the internal S, lo, hi and count registers. RESET overrides TRESET and RDY.
- Output values in IDLE: ADDR=0, RW=1, ACTIVE=0, S_WE=0, PC_LOAD=0, SYNC=0, S_OUT=0, PC_OUT=0.
- TRESET=1 (RESET=0), from any state: next state HOLD. Aborts any sequence in progress; no PC_LOAD or S_WE is issued for the aborted sequence.
- HOLD: ADDR=PC_IN, ACTIVE=1. On the edge where TRESET=0, capture S_IN into internal S and go to DUM with count 0.
- DUM (2 cycles): ADDR=PC_IN. After count 1, go to PUSH with count 0.
- PUSH (NUM_PUSH cycles):
  - ADDR={STACK_PAGE,S}.
  - S_OUT=S-1 (mod 256, so 8'h00 wraps to 8'hFF), S_WE=1.
  - Internal S<=S-1 on each advancing edge.
  - After the last push, go to VLO.
- VLO: ADDR=VEC_ADDR; capture DIN into lo on the advancing edge. Go to VHI.
- VHI: ADDR=VEC_ADDR+1 (16-bit wrap); capture DIN into hi. Go to FETCH.
- FETCH:
  - PC_OUT={hi,lo}, PC_LOAD=1 for exactly one cycle, ADDR={hi,lo}, SYNC=1.
  - Go to IDLE unconditionally; FETCH ignores RDY and is the handoff to the core.
- IDLE: ACTIVE=0; the block waits for TRESET.
- RDY=0 in DUM, PUSH, VLO or VHI:
  - State, count, S, lo and hi all hold.
  - ADDR is held.
  - S_WE is forced to 0 during the stall, so S is written exactly once per push.
  - RDY=0 in HOLD is ignored; TRESET governs HOLD.
- Latency:
  - From the first edge where TRESET=0 in HOLD to PC_LOAD = 2+NUM_PUSH+2+1 cycles, plus the number of RDY-low cycles.
  - With defaults and no stalls, PC_LOAD/SYNC appear on the 8th cycle after leaving HOLD (7 sequence cycles + fetch).
- All outputs are combinational from registered state only; no combinational path from DIN to any output.

Test Plan:
- Basic sequence: RESET 2 cycles, TRESET 1 for 5 cycles then 0, S_IN=8'hFD, PC_IN=16'h1234, RDY=1, DIN=8'h00 in VLO and 8'hC0 in VHI.
  - ADDR sequence 1234,1234,01FD,01FC,01FB,FFFC,FFFD,C000.
  - S_WE with S_OUT FC,FB,FA.
  - PC_LOAD=1 and SYNC=1 with PC_OUT=16'hC000 for one cycle, then ACTIVE=0.
- Stack wrap: S_IN=8'h01 -> push addresses 0101,0100,01FF; S_OUT 00,FF,FE.
- RDY stall: RDY=0 for 3 cycles during the second PUSH.
  - ADDR held at 01FC for those cycles, S_WE=0.
  - Only 3 S_WE pulses in total; PC_LOAD delayed by exactly 3 cycles.
- Abort: TRESET re-asserted during VLO.
  - Next state HOLD; no PC_LOAD.
  - After TRESET falls again, a full fresh sequence runs with S recaptured from S_IN.
- Priority: RESET and TRESET both high mid-PUSH -> state IDLE, ACTIVE=0, all strobes 0.
  - After RESET drops with TRESET still high, the next cycle is HOLD.
- Parameter: NUM_PUSH=1, VEC_ADDR=16'hFFFA.
  - ADDR sequence PC,PC,01S,FFFA,FFFB,vector; PC_LOAD 6 cycles after leaving HOLD.
